// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy and error-flag control for a DEPTH-entry
// FIFO whose storage array lives outside this block.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   clr                 synchronous flush of pointers and count (errors kept)
//   wr_en, rd_en        write / read requests
//   err_clr             synchronous clear of the sticky error flags
//   waddr, raddr        storage addresses, 0..DEPTH-1, wrapping
//   wr_ok, rd_ok        combinational accept strobes for this cycle
//   count               occupied entries, 0..DEPTH
//   full, empty,
//   almost_full,
//   almost_empty        occupancy flags decoded from the registered count
//   overflow, underflow sticky: write while full / read while empty
module fifo_ptr_ctrl #(
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFT  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AET  = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  // Flags come from the registered count only, so no request input reaches
  // them; they follow an accepted operation one cycle later.
  assign full         = (count == CMAX);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFT);
  assign almost_empty = (count <= AET);

  // Because full blocks only the write and empty blocks only the read, a
  // simultaneous request at either boundary accepts exactly one side.
  // rst gating keeps wr_ok low during reset even though full is already 0.
  assign wr_ok = wr_en & ~full  & ~clr & ~rst;
  assign rd_ok = rd_en & ~empty & ~clr & ~rst;

  // Error events look at the raw request, independent of clr.
  logic ov_set, un_set;
  assign ov_set = wr_en & full;
  assign un_set = rd_en & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else if (clr) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) waddr <= (waddr == LAST) ? '0 : waddr + AW'(1);
      if (rd_ok) raddr <= (raddr == LAST) ? '0 : raddr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_set | (overflow  & ~err_clr);
      underflow <= un_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: two instances (DEPTH=5 with default thresholds, and
// DEPTH=16 / AFULL_TH=14 / AEMPTY_TH=2) share one directed stimulus stream.
// A per-instance occupancy model (running totals and modulo arithmetic) is
// compared against every output on each falling edge; directed literal
// checks pin the model to hand-computed values.
module tb_fifo_ptr_ctrl;

  logic clk = 1'b0;
  logic rst, clr, wr_en, rd_en, err_clr;

  always #5 clk = ~clk;

  // DEPTH=5 instance
  logic [2:0] wa5, ra5;
  logic [3:0] c5;
  logic wok5, rok5, f5, e5, af5, ae5, ov5, un5;
  // DEPTH=16 instance
  logic [3:0] wa16, ra16;
  logic [4:0] c16;
  logic wok16, rok16, f16, e16, af16, ae16, ov16, un16;

  fifo_ptr_ctrl #(.DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .waddr(wa5), .raddr(ra5), .wr_ok(wok5), .rd_ok(rok5),
    .count(c5), .full(f5), .empty(e5), .almost_full(af5),
    .almost_empty(ae5), .overflow(ov5), .underflow(un5));

  fifo_ptr_ctrl #(.DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2)) u16 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .waddr(wa16), .raddr(ra16), .wr_ok(wok16),
    .rd_ok(rok16), .count(c16), .full(f16), .empty(e16), .almost_full(af16),
    .almost_empty(ae16), .overflow(ov16), .underflow(un16));

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Occupancy is writes accepted minus reads accepted; pointers are the
  // number of accepted operations since the last flush, modulo DEPTH.
  int m5_cnt, m5_wa, m5_ra;   bit m5_ov, m5_un;
  int m16_cnt, m16_wa, m16_ra; bit m16_ov, m16_un;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m5_cnt <= 0; m5_wa <= 0; m5_ra <= 0; m5_ov <= 0; m5_un <= 0;
    end else begin
      automatic int w = (wr_en && !clr && m5_cnt < 5) ? 1 : 0;
      automatic int r = (rd_en && !clr && m5_cnt > 0) ? 1 : 0;
      m5_cnt <= clr ? 0 : m5_cnt + w - r;
      m5_wa  <= clr ? 0 : (m5_wa + w) % 5;
      m5_ra  <= clr ? 0 : (m5_ra + r) % 5;
      m5_ov  <= (wr_en && m5_cnt == 5) || (m5_ov && !err_clr);
      m5_un  <= (rd_en && m5_cnt == 0) || (m5_un && !err_clr);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16_cnt <= 0; m16_wa <= 0; m16_ra <= 0; m16_ov <= 0; m16_un <= 0;
    end else begin
      automatic int w = (wr_en && !clr && m16_cnt < 16) ? 1 : 0;
      automatic int r = (rd_en && !clr && m16_cnt > 0) ? 1 : 0;
      m16_cnt <= clr ? 0 : m16_cnt + w - r;
      m16_wa  <= clr ? 0 : (m16_wa + w) % 16;
      m16_ra  <= clr ? 0 : (m16_ra + r) % 16;
      m16_ov  <= (wr_en && m16_cnt == 16) || (m16_ov && !err_clr);
      m16_un  <= (rd_en && m16_cnt == 0) || (m16_un && !err_clr);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    automatic bit live = !rst;
    // DEPTH=5, AFULL_TH=3, AEMPTY_TH=2
    chk("m5.waddr", int'(wa5), m5_wa);
    chk("m5.raddr", int'(ra5), m5_ra);
    chk("m5.count", int'(c5), m5_cnt);
    chk("m5.full",  int'(f5), int'(m5_cnt == 5));
    chk("m5.empty", int'(e5), int'(m5_cnt == 0));
    chk("m5.afull", int'(af5), int'(m5_cnt >= 3));
    chk("m5.aempty", int'(ae5), int'(m5_cnt <= 2));
    chk("m5.ovf", int'(ov5), int'(m5_ov));
    chk("m5.unf", int'(un5), int'(m5_un));
    chk("m5.wr_ok", int'(wok5), int'(live && wr_en && !clr && m5_cnt < 5));
    chk("m5.rd_ok", int'(rok5), int'(live && rd_en && !clr && m5_cnt > 0));
    // DEPTH=16, AFULL_TH=14, AEMPTY_TH=2
    chk("m16.waddr", int'(wa16), m16_wa);
    chk("m16.raddr", int'(ra16), m16_ra);
    chk("m16.count", int'(c16), m16_cnt);
    chk("m16.full",  int'(f16), int'(m16_cnt == 16));
    chk("m16.empty", int'(e16), int'(m16_cnt == 0));
    chk("m16.afull", int'(af16), int'(m16_cnt >= 14));
    chk("m16.aempty", int'(ae16), int'(m16_cnt <= 2));
    chk("m16.ovf", int'(ov16), int'(m16_ov));
    chk("m16.unf", int'(un16), int'(m16_un));
    chk("m16.wr_ok", int'(wok16), int'(live && wr_en && !clr && m16_cnt < 16));
    chk("m16.rd_ok", int'(rok16), int'(live && rd_en && !clr && m16_cnt > 0));
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit w, input bit r, input bit c, input bit e);
    wr_en = w; rd_en = r; clr = c; err_clr = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit w, input bit r, input bit c, input bit e);
    drive(w, r, c, e);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count5", int'(c5), 0);
    chk("rst.empty5", int'(e5), 1);
    chk("rst.afull5", int'(af5), 0);
    chk("rst.aempty5", int'(ae5), 1);
    rst = 1'b0;
    tick();

    // Fill DEPTH=5: waddr 1,2,3,4,0
    for (int i = 0; i < 5; i++) begin
      op(1, 0, 0, 0);
      chk("fill.waddr5", int'(wa5), (i + 1) % 5);
    end
    chk("fill.full5", int'(f5), 1);
    chk("fill.count5", int'(c5), 5);
    drive(1, 0, 0, 0); #1;
    chk("fill.6th_wr_ok5", int'(wok5), 0);
    tick();
    chk("fill.ovf5", int'(ov5), 1);
    chk("fill.count16", int'(c16), 6);

    // Drain past empty: raddr 1,2,3,4,0
    for (int i = 0; i < 5; i++) begin
      op(0, 1, 0, 0);
      chk("drain.raddr5", int'(ra5), (i + 1) % 5);
    end
    chk("drain.empty5", int'(e5), 1);
    drive(0, 1, 0, 0); #1;
    chk("drain.6th_rd_ok5", int'(rok5), 0);
    tick();
    chk("drain.unf5", int'(un5), 1);
    chk("drain.count16", int'(c16), 0);
    chk("drain.raddr16", int'(ra16), 6);

    op(0, 0, 0, 1);
    chk("errclr.ovf5", int'(ov5), 0);
    chk("errclr.unf5", int'(un5), 0);

    // Simultaneous at count 3
    repeat (3) op(1, 0, 0, 0);
    repeat (4) op(1, 1, 0, 0);
    chk("simul.count5", int'(c5), 3);
    chk("simul.waddr5", int'(wa5), 2);
    chk("simul.raddr5", int'(ra5), 4);
    chk("simul.waddr16", int'(wa16), 13);
    chk("simul.raddr16", int'(ra16), 10);

    // Both requested while full
    repeat (2) op(1, 0, 0, 0);
    chk("full.count5", int'(c5), 5);
    op(1, 1, 0, 0);
    chk("fullboth.count5", int'(c5), 4);
    chk("fullboth.ovf5", int'(ov5), 1);
    chk("fullboth.count16", int'(c16), 5);

    // Both requested while empty
    repeat (4) op(0, 1, 0, 0);
    chk("empty.empty5", int'(e5), 1);
    op(1, 1, 0, 0);
    chk("emptyboth.count5", int'(c5), 1);
    chk("emptyboth.unf5", int'(un5), 1);

    // Thresholds on DEPTH=16 (count16 is 1 here)
    op(1, 0, 0, 0);
    chk("th.aempty16_at2", int'(ae16), 1);
    op(1, 0, 0, 0);
    chk("th.aempty16_at3", int'(ae16), 0);
    repeat (10) op(1, 0, 0, 0);
    chk("th.count16", int'(c16), 13);
    chk("th.afull16_at13", int'(af16), 0);
    op(1, 0, 0, 0);
    chk("th.afull16_at14", int'(af16), 1);

    // clr with count 7 and overflow set
    repeat (2) op(1, 0, 0, 0);
    chk("clr.full16", int'(f16), 1);
    op(1, 0, 0, 0);
    chk("clr.ovf16", int'(ov16), 1);
    repeat (9) op(0, 1, 0, 0);
    chk("clr.count16_pre", int'(c16), 7);
    drive(1, 0, 1, 0); #1;
    chk("clr.wr_ok16", int'(wok16), 0);
    tick();
    chk("clr.count16", int'(c16), 0);
    chk("clr.waddr16", int'(wa16), 0);
    chk("clr.raddr16", int'(ra16), 0);
    chk("clr.ovf16_kept", int'(ov16), 1);

    // err_clr vs. new overflow event on DEPTH=5
    repeat (5) op(1, 0, 0, 0);
    op(1, 0, 0, 0);
    chk("err.ovf5_set", int'(ov5), 1);
    op(1, 0, 0, 1);
    chk("err.set_wins5", int'(ov5), 1);
    op(0, 0, 0, 1);
    chk("err.cleared5", int'(ov5), 0);

    // Async reset at count 9
    repeat (2) op(1, 0, 0, 0);
    chk("arst.count16_pre", int'(c16), 9);
    #2 rst = 1'b1;
    #1;
    chk("arst.count16", int'(c16), 0);
    chk("arst.waddr16", int'(wa16), 0);
    chk("arst.raddr16", int'(ra16), 0);
    chk("arst.empty16", int'(e16), 1);
    chk("arst.full16", int'(f16), 0);
    chk("arst.aempty16", int'(ae16), 1);
    chk("arst.afull16", int'(af16), 0);
    chk("arst.ovf16", int'(ov16), 0);
    chk("arst.wr_ok16", int'(wok16), 0);
    chk("arst.full5", int'(f5), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst.first_wr_waddr16", int'(wa16), 1);
    chk("arst.first_wr_count16", int'(c16), 1);
    repeat (3) op(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
